// File: rtl/net_rate_limiter.sv
// Token-bucket throttle for the 64-bit NIC transmit stream.
// Pass-through datapath gated by a token count that refills every rlimit_period+1 cycles.
module net_rate_limiter #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic [7:0]        rlimit_inc,
    input  logic [7:0]        rlimit_period,
    input  logic [7:0]        rlimit_size,
    output logic [CNT_W-1:0]  stat_beats,
    output logic [CNT_W-1:0]  stat_frames,
    output logic [CNT_W-1:0]  stat_stalls
);

    logic [7:0] tokens;
    logic [7:0] cyc;
    logic [7:0] inc_q;
    logic [7:0] period_q;
    logic [7:0] size_q;
    logic       in_frame;

    logic       has_tok;
    logic       fire;
    logic       refill;
    logic [9:0] tok_sum;
    logic [7:0] tokens_nxt;

    // Handshake: a beat transfers on a cycle where in_valid & out_ready & has_tok;
    // valid never waits on ready, and both directions are gated by token availability.
    assign has_tok   = (tokens != 8'd0);
    assign out_valid = in_valid & has_tok;
    assign in_ready  = out_ready & has_tok;
    assign fire      = in_valid & out_ready & has_tok;

    assign out_data  = in_data;
    assign out_keep  = in_keep;
    assign out_last  = in_last;

    // >= rather than == so a period shrink at a frame boundary cannot skip a wrap.
    assign refill = (cyc >= period_q);

    always_comb begin
        tok_sum    = {2'b00, tokens} - {9'd0, fire};
        tokens_nxt = tokens;
        if (refill) begin
            tok_sum = tok_sum + {2'b00, inc_q};
        end
        if (tok_sum > {2'b00, size_q}) begin
            tokens_nxt = size_q;
        end else begin
            tokens_nxt = tok_sum[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tokens   <= 8'd0;
            cyc      <= 8'd0;
            inc_q    <= 8'd0;
            period_q <= 8'd0;
            size_q   <= 8'd0;
            in_frame <= 1'b0;
        end else begin
            tokens <= tokens_nxt;
            cyc    <= refill ? 8'd0 : cyc + 8'd1;
            // Rate settings only change between frames.
            if (!in_frame) begin
                inc_q    <= rlimit_inc;
                period_q <= rlimit_period;
                size_q   <= rlimit_size;
            end
            if (fire) begin
                in_frame <= !in_last;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats  <= '0;
            stat_frames <= '0;
            stat_stalls <= '0;
        end else begin
            if (fire) begin
                stat_beats <= stat_beats + CNT_W'(1);
            end
            if (fire && in_last) begin
                stat_frames <= stat_frames + CNT_W'(1);
            end
            if (in_valid && !has_tok) begin
                stat_stalls <= stat_stalls + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_net_rate_limiter.sv
// Directed bench for net_rate_limiter: rate, burst, config latching, backpressure and reset.
// Expected cycle positions below are hand-derived from the token/period arithmetic.
module tb_net_rate_limiter;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEEP_W-1:0] in_keep = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              out_last;
    logic [7:0]        rlimit_inc = '0;
    logic [7:0]        rlimit_period = '0;
    logic [7:0]        rlimit_size = '0;
    logic [CNT_W-1:0]  stat_beats;
    logic [CNT_W-1:0]  stat_frames;
    logic [CNT_W-1:0]  stat_stalls;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    int beat_cyc[$];

    net_rate_limiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .rlimit_inc(rlimit_inc), .rlimit_period(rlimit_period), .rlimit_size(rlimit_size),
        .stat_beats(stat_beats), .stat_frames(stat_frames), .stat_stalls(stat_stalls)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input logic [7:0] inc, input logic [7:0] per, input logic [7:0] size);
        in_valid      = 1'b0;
        in_last       = 1'b0;
        out_ready     = 1'b1;
        rlimit_inc    = inc;
        rlimit_period = per;
        rlimit_size   = size;
        reset_n       = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives an n-beat frame; cycles counts every cycle spent, beat_cyc holds the
    // 1-based cycle index of each accepted beat. rlimit_period becomes chg_val
    // once chg_at beats have been accepted (chg_at=0 disables the change).
    task automatic send_frame(input int n, input int chg_at, input logic [7:0] chg_val,
                              input int max_cyc, output int cycles);
        int beat;
        logic [DATA_W-1:0] exp_d;
        beat   = 0;
        cycles = 0;
        beat_cyc.delete();
        while (beat < n && cycles < max_cyc) begin
            in_valid = 1'b1;
            in_last  = (beat == n - 1);
            in_data  = {$urandom, $urandom};
            in_keep  = KEEP_W'($urandom_range(0, 255));
            exp_q.push_back(in_data);
            @(negedge clock);
            cycles++;
            exp_d = exp_q.pop_front();
            check_eq("out_data", out_data, exp_d);
            if (in_ready) begin
                check_eq("out_valid_on_accept", 64'(out_valid), 64'd1);
                check_eq("out_keep", 64'(out_keep), 64'(in_keep));
                check_eq("out_last", 64'(out_last), 64'(in_last));
                beat++;
                beat_cyc.push_back(cycles);
                if (beat == chg_at) rlimit_period = chg_val;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (beat < n) check_eq("frame_timeout", 64'(beat), 64'(n));
    endtask

    initial begin
        int cycles;
        int acc;

        // Reset state
        apply_reset(8'd1, 8'd0, 8'd8);
        @(negedge clock);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_beats", 64'(stat_beats), 64'd0);
        check_eq("rst_frames", 64'(stat_frames), 64'd0);
        check_eq("rst_stalls", 64'(stat_stalls), 64'd0);

        // Full rate: one warm-up stall then one beat per cycle
        apply_reset(8'd1, 8'd0, 8'd8);
        idle(1);
        send_frame(100, 0, 8'd0, 300, cycles);
        check_eq("full_cycles", 64'(cycles), 64'd101);
        check_eq("full_first", 64'(beat_cyc[0]), 64'd2);
        check_eq("full_last", 64'(beat_cyc[99]), 64'd101);
        check_eq("full_beats", 64'(stat_beats), 64'd100);
        check_eq("full_stalls", 64'(stat_stalls), 64'd1);
        check_eq("full_frames", 64'(stat_frames), 64'd1);

        // Half rate: beats on odd cycles from cycle 3
        apply_reset(8'd1, 8'd1, 8'd1);
        idle(1);
        for (int k = 1; k <= 200; k++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            @(negedge clock);
            check_eq("half_out_valid", 64'(out_valid), 64'((k >= 3) && (k % 2 == 1)));
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("half_beats", 64'(stat_beats), 64'd99);
        check_eq("half_stalls", 64'(stat_stalls), 64'd101);
        check_eq("half_frames", 64'(stat_frames), 64'd99);

        // Burst: full bucket plus coincident refill gives 9 back-to-back beats
        apply_reset(8'd4, 8'd15, 8'd8);
        idle(64);
        send_frame(20, 0, 8'd0, 200, cycles);
        check_eq("burst_cycles", 64'(cycles), 64'd52);
        check_eq("burst_9th", 64'(beat_cyc[8]), 64'd9);
        check_eq("burst_10th", 64'(beat_cyc[9]), 64'd18);
        check_eq("burst_14th", 64'(beat_cyc[13]), 64'd34);
        check_eq("burst_beats", 64'(stat_beats), 64'd20);
        check_eq("burst_stalls", 64'(stat_stalls), 64'd32);
        check_eq("burst_frames", 64'(stat_frames), 64'd1);

        // Mid-frame config change applies only to the next frame
        apply_reset(8'd1, 8'd0, 8'd8);
        idle(2);
        send_frame(10, 3, 8'd7, 100, cycles);
        check_eq("cfg_f1_cycles", 64'(cycles), 64'd10);
        send_frame(4, 0, 8'd0, 100, cycles);
        check_eq("cfg_f2_cycles", 64'(cycles), 64'd18);
        check_eq("cfg_f2_2nd", 64'(beat_cyc[1]), 64'd2);
        check_eq("cfg_f2_3rd", 64'(beat_cyc[2]), 64'd10);
        check_eq("cfg_beats", 64'(stat_beats), 64'd14);
        check_eq("cfg_stalls", 64'(stat_stalls), 64'd14);
        check_eq("cfg_frames", 64'(stat_frames), 64'd2);

        // Backpressure with a bucket saturated at size 3 and refill disabled
        apply_reset(8'd1, 8'd0, 8'd3);
        idle(10);
        rlimit_inc = 8'd0;
        idle(2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check_eq("bp_stalls_held", 64'(stat_stalls), 64'd0);
        check_eq("bp_beats_held", 64'(stat_beats), 64'd0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 0) check_eq("bp_release_ready", 64'(in_ready), 64'd1);
            if (in_ready) acc++;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("bp_accepted", 64'(acc), 64'd3);
        check_eq("bp_beats", 64'(stat_beats), 64'd3);
        check_eq("bp_frames", 64'(stat_frames), 64'd3);
        check_eq("bp_stalls", 64'(stat_stalls), 64'd3);

        // Async reset mid-frame, asserted between clock edges
        apply_reset(8'd1, 8'd0, 8'd8);
        idle(3);
        in_valid = 1'b1;
        in_last  = 1'b0;
        idle(3);
        @(negedge clock);
        check_eq("ar_pre_beats", 64'(stat_beats), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_out_valid", 64'(out_valid), 64'd0);
        check_eq("ar_in_ready", 64'(in_ready), 64'd0);
        check_eq("ar_beats", 64'(stat_beats), 64'd0);
        check_eq("ar_frames", 64'(stat_frames), 64'd0);
        check_eq("ar_stalls", 64'(stat_stalls), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            check_eq("ar_restart_ready", 64'(in_ready), 64'(k == 3));
            if (k == 3) check_eq("ar_restart_stalls", 64'(stat_stalls), 64'd2);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
